// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock using a
// ripple-carry trial subtraction, with a one-cycle divide-by-zero shortcut.
module restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_partial;
    logic [WIDTH-1:0] r_quot;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH+1:0] w_carry;
    logic             w_qbit;
    logic [WIDTH:0]   w_partial_next;
    logic [WIDTH-1:0] w_quot_next;
    logic             w_unused_top;

    // The partial remainder never exceeds the divisor after restoring, so its
    // top bit is always zero going into the shift.
    assign w_unused_top = r_partial[WIDTH];
    assign w_shifted    = {r_partial[WIDTH-1:0], r_dividend[WIDTH-1]};
    assign w_addend     = ~{1'b0, r_divisor};
    assign w_carry[0]   = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_fa
            assign w_sum[gi]     = w_shifted[gi] ^ w_addend[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (w_shifted[gi] & w_addend[gi])
                                 | (w_carry[gi] & (w_shifted[gi] ^ w_addend[gi]));
        end
    endgenerate

    // Carry-out set means no borrow: the divisor fits into the shifted partial.
    assign w_qbit         = w_carry[WIDTH+1];
    assign w_partial_next = w_qbit ? w_sum : w_shifted;
    assign w_quot_next    = {r_quot[WIDTH-2:0], w_qbit};

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_partial   <= '0;
            r_quot      <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            r_dividend <= dividend;
                            r_divisor  <= divisor;
                            r_partial  <= '0;
                            r_quot     <= '0;
                            r_count    <= CW'(WIDTH - 1);
                            r_busy     <= 1'b1;
                            r_state    <= StRun;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                end
                StRun: begin
                    r_partial  <= w_partial_next;
                    r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                    r_quot     <= w_quot_next;
                    if (r_count == '0) begin
                        r_quotient  <= w_quot_next;
                        r_remainder <= w_partial_next[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbz       = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized checks of restoring_divider at WIDTH=8.
module tb_restoring_divider;

    logic       CLOCK_50;
    logic       resetn;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    int n_checks = 0;
    int n_errors = 0;

    restoring_divider #(.WIDTH(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one division and follow it to completion. inject_at > 0 pulses a
    // competing start on that RUN cycle, which must be ignored.
    task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int inject_at);
        logic [7:0] exp_q, exp_r, hold_q, hold_r;
        logic       exp_dbz, hold_dbz;
        int         lat;
        if (b == 8'd0) begin
            exp_q = 8'hFF; exp_r = a; exp_dbz = 1'b1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dbz = 1'b0;
        end
        hold_q = quotient; hold_r = remainder; hold_dbz = dbz;
        dividend = a; divisor = b; start = 1'b1;
        tick();
        start = 1'b0;
        dividend = ~a; divisor = b ^ 8'h5A;
        lat = 1;
        while (!done && lat < 40) begin
            chk({tag, " busy"}, 32'(busy), 32'(1));
            chk({tag, " hold"}, {15'd0, hold_dbz, hold_r, hold_q},
                {15'd0, dbz, remainder, quotient});
            if (lat == inject_at) begin
                start = 1'b1; dividend = 8'd9; divisor = 8'd3;
            end else begin
                start = 1'b0; dividend = 8'hAA; divisor = 8'd0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        chk({tag, " done"}, 32'(done), 32'(1));
        chk({tag, " latency"}, 32'(lat), exp_dbz ? 32'd1 : 32'd9);
        chk({tag, " busy_at_done"}, 32'(busy), 32'(0));
        chk({tag, " quotient"}, 32'(quotient), 32'(exp_q));
        chk({tag, " remainder"}, 32'(remainder), 32'(exp_r));
        chk({tag, " dbz"}, 32'(dbz), 32'(exp_dbz));
        tick();
        chk({tag, " done_pulse"}, 32'(done), 32'(0));
    endtask

    initial begin
        logic [7:0] ra, rb;
        resetn = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        #3;
        chk("reset outputs", {13'd0, dbz, done, busy, remainder, quotient}, 32'd0);
        #10;
        resetn = 1'b1;
        tick();

        do_div("100/7", 8'd100, 8'd7, 0);
        do_div("255/1", 8'd255, 8'd1, 0);
        do_div("5/9", 8'd5, 8'd9, 0);
        do_div("0/3", 8'd0, 8'd3, 0);
        do_div("37/0", 8'd37, 8'd0, 0);
        do_div("6/3", 8'd6, 8'd3, 0);
        do_div("255/255", 8'd255, 8'd255, 0);
        do_div("200/13 inject", 8'd200, 8'd13, 4);
        for (int i = 0; i < 12; i++) begin
            chk("no second done", {30'd0, busy, done}, 32'd0);
            tick();
        end

        // Abort a division with reset on RUN cycle 5.
        dividend = 8'd200; divisor = 8'd13; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        resetn = 1'b0;
        #1;
        chk("async reset", {13'd0, dbz, done, busy, remainder, quotient}, 32'd0);
        repeat (2) begin
            tick();
            chk("reset no done", {30'd0, busy, done}, 32'd0);
        end
        #3;
        resetn = 1'b1;
        tick();
        do_div("50/6 after reset", 8'd50, 8'd6, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 50 == 7) rb = 8'd0;
            do_div("random", ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
